pcsp_seq: RTL and testbench

Sequential program-counter/stack-pointer unit for the 8085 core, and the consumer of the 16-bit incdec datapath. It owns PC and SP and runs single-step PC advance, register loads, and two-step PUSH/POP stack sequences. Each step drives one shared incdec instance and presents a memory address per step to the bus sequencer. It sits between the instruction control FSM (requester) and the address bus mux.

---
 rtl/pcsp_seq_pkg.sv | 30 +++
 rtl/pcsp_seq_incdec.sv | 24 ++
 rtl/pcsp_seq.sv | 159 +++++++++++++++
 tb/tb_pcsp_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pcsp_seq_pkg.sv
// Shared definitions for the PC/SP sequencer:
// op codes, FSM states and reset defaults.
package pcsp_seq_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_PCINC  = 3'd1;
  localparam logic [2:0] OP_LDPC   = 3'd2;
  localparam logic [2:0] OP_LDSP   = 3'd3;
  localparam logic [2:0] OP_PUSH2  = 3'd4;
  localparam logic [2:0] OP_POP2   = 3'd5;
  localparam logic [2:0] OP_PCINC2 = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP1 = 2'd1,
    ST_STEP2 = 2'd2
  } state_e;

  localparam int RST_PC_DEF = 0;
  localparam int RST_SP_DEF = 0;

  function automatic logic is_two_step(
    input logic [2:0] op
  );
    return (op == OP_PUSH2) ||
           (op == OP_POP2)  ||
           (op == OP_PCINC2);
  endfunction

endpackage

// File: rtl/pcsp_seq_incdec.sv
// 16-bit incrementer/decrementer datapath.
// oF[0] is carry out (inc) or borrow (dec).
module incdec #(
  parameter int DATASIZE = 16
) (
  input  logic [DATASIZE-1:0] iA,
  input  logic                iS,
  output logic [DATASIZE-1:0] oY,
  output logic [0:0]          oF
);

  localparam logic [DATASIZE:0] ONE = 1;

  logic [DATASIZE:0] ext;

  always_comb begin
    if (iS) ext = {1'b0, iA} - ONE;
    else    ext = {1'b0, iA} + ONE;
  end

  assign oY    = ext[DATASIZE-1:0];
  assign oF[0] = ext[DATASIZE];

endmodule

// File: rtl/pcsp_seq.sv
// PC/SP owner: single-step PC advance, loads,
// and two-step PUSH/POP through one shared incdec.
module pcsp_seq
  import pcsp_seq_pkg::*;
#(
  parameter int DATASIZE = 16,
  parameter int RSTPC    = RST_PC_DEF,
  parameter int RSTSP    = RST_SP_DEF
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iReq,
  input  logic [2:0]          iOp,
  input  logic [DATASIZE-1:0] iData,
  output logic                oBusy,
  output logic                oDone,
  output logic                oStep,
  output logic [DATASIZE-1:0] oAddr,
  output logic [DATASIZE-1:0] oPC,
  output logic [DATASIZE-1:0] oSP,
  output logic                oWrap
);

  state_e state, nstate;
  logic [2:0] op_q;

  logic [DATASIZE-1:0] pc, sp, addr;
  logic [DATASIZE-1:0] pc_d, sp_d, addr_d;
  logic wrap, step, done;
  logic wrap_d, step_d, done_d;

  logic accept, arith;
  logic [2:0] cur_op;
  logic is_push, is_pop, is_pinc2;
  logic is_pinc, is_ldpc, is_ldsp;

  logic [DATASIZE-1:0] id_a, id_y;
  logic [0:0] id_f;
  logic id_s;

  assign accept = iReq && (state == ST_IDLE);
  assign arith  = accept || (state == ST_STEP1);
  assign cur_op = (state == ST_IDLE) ? iOp : op_q;

  assign is_push  = cur_op == OP_PUSH2;
  assign is_pop   = cur_op == OP_POP2;
  assign is_pinc2 = cur_op == OP_PCINC2;
  assign is_pinc  = cur_op == OP_PCINC;
  assign is_ldpc  = cur_op == OP_LDPC;
  assign is_ldsp  = cur_op == OP_LDSP;

  // Stack ops route SP through the shared
  // incdec; everything else advances PC.
  assign id_a = (is_push || is_pop) ? sp : pc;
  assign id_s = is_push;

  incdec #(
    .DATASIZE(DATASIZE)
  ) u_incdec (
    .iA(id_a),
    .iS(id_s),
    .oY(id_y),
    .oF(id_f)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= ST_IDLE;
      op_q  <= OP_NOP;
    end else begin
      state <= nstate;
      if (accept) op_q <= iOp;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:
        if (accept && is_two_step(iOp))
          nstate = ST_STEP1;
      ST_STEP1: nstate = ST_STEP2;
      ST_STEP2: nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc;
    sp_d   = sp;
    addr_d = addr;
    wrap_d = wrap;
    step_d = 1'b0;
    done_d = 1'b0;
    if (state == ST_STEP2) begin
      done_d = 1'b1;
    end else if (arith) begin
      unique case (1'b1)
        is_push: begin
          sp_d   = id_y;
          addr_d = id_y;
          step_d = 1'b1;
          wrap_d = id_f[0];
        end
        is_pop: begin
          sp_d   = id_y;
          addr_d = sp;
          step_d = 1'b1;
          wrap_d = id_f[0];
        end
        is_pinc2: begin
          pc_d   = id_y;
          wrap_d = id_f[0];
        end
        is_pinc: begin
          pc_d   = id_y;
          wrap_d = id_f[0];
          done_d = 1'b1;
        end
        is_ldpc: begin
          pc_d   = iData;
          done_d = 1'b1;
        end
        is_ldsp: begin
          sp_d   = iData;
          done_d = 1'b1;
        end
        default: done_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc   <= DATASIZE'(RSTPC);
      sp   <= DATASIZE'(RSTSP);
      addr <= '0;
      wrap <= 1'b0;
      step <= 1'b0;
      done <= 1'b0;
    end else begin
      pc   <= pc_d;
      sp   <= sp_d;
      addr <= addr_d;
      wrap <= wrap_d;
      step <= step_d;
      done <= done_d;
    end
  end

  assign oBusy = state != ST_IDLE;
  assign oDone = done;
  assign oStep = step;
  assign oAddr = addr;
  assign oPC   = pc;
  assign oSP   = sp;
  assign oWrap = wrap;

endmodule

// File: tb/tb_pcsp_seq.sv
// Directed bench for pcsp_seq with a queue of
// expected step addresses checked on each oStep.
module tb_pcsp_seq;
  import pcsp_seq_pkg::*;

  logic        iClk;
  logic        iRstN;
  logic        iReq;
  logic [2:0]  iOp;
  logic [15:0] iData;
  logic        oBusy, oDone, oStep, oWrap;
  logic [15:0] oAddr, oPC, oSP;

  int pass_cnt = 0;
  int total    = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  pcsp_seq #(
    .DATASIZE(16),
    .RSTPC(0),
    .RSTSP(0)
  ) dut (
    .iClk(iClk),
    .iRstN(iRstN),
    .iReq(iReq),
    .iOp(iOp),
    .iData(iData),
    .oBusy(oBusy),
    .oDone(oDone),
    .oStep(oStep),
    .oAddr(oAddr),
    .oPC(oPC),
    .oSP(oSP),
    .oWrap(oWrap)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s got=%0h want=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    logic [15:0] e;
    @(posedge iClk);
    #1;
    chk("step_done_excl",
        {31'b0, oStep & oDone}, 0);
    if (oStep) begin
      if (exp_q.size() == 0) begin
        chk("unexp_step", {31'b0, oStep}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("step_addr", {16'b0, oAddr}, {16'b0, e});
      end
    end
    if (oDone) done_cnt++;
  endtask

  task automatic req(
    input logic [2:0]  op,
    input logic [15:0] d
  );
    iReq  = 1'b1;
    iOp   = op;
    iData = d;
    tick();
    iReq  = 1'b0;
  endtask

  initial begin
    iRstN = 1'b0;
    iReq  = 1'b0;
    iOp   = OP_NOP;
    iData = '0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_pc", {16'b0, oPC}, 0);
    chk("rst_sp", {16'b0, oSP}, 0);
    chk("rst_busy", {31'b0, oBusy}, 0);
    chk("rst_done", {31'b0, oDone}, 0);
    chk("rst_step", {31'b0, oStep}, 0);
    chk("rst_wrap", {31'b0, oWrap}, 0);
    chk("rst_addr", {16'b0, oAddr}, 0);
    iRstN = 1'b1;
    tick();

    // LOAD_SP then PUSH2
    req(OP_LDSP, 16'h2000);
    chk("ldsp_done", {31'b0, oDone}, 1);
    chk("ldsp_sp", {16'b0, oSP}, 32'h2000);
    chk("ldsp_busy", {31'b0, oBusy}, 0);
    exp_q.push_back(16'h1FFF);
    exp_q.push_back(16'h1FFE);
    req(OP_PUSH2, 16'h0);
    chk("push_s1_step", {31'b0, oStep}, 1);
    chk("push_s1_busy", {31'b0, oBusy}, 1);
    tick();
    chk("push_s2_step", {31'b0, oStep}, 1);
    chk("push_s2_busy", {31'b0, oBusy}, 1);
    tick();
    chk("push_done", {31'b0, oDone}, 1);
    chk("push_busy_end", {31'b0, oBusy}, 0);
    chk("push_sp", {16'b0, oSP}, 32'h1FFE);
    chk("push_hold_addr", {16'b0, oAddr}, 32'h1FFE);

    // POP2
    exp_q.push_back(16'h1FFE);
    exp_q.push_back(16'h1FFF);
    req(OP_POP2, 16'h0);
    chk("pop_s1_step", {31'b0, oStep}, 1);
    tick();
    chk("pop_s2_step", {31'b0, oStep}, 1);
    tick();
    chk("pop_done", {31'b0, oDone}, 1);
    chk("pop_sp", {16'b0, oSP}, 32'h2000);
    chk("pop_wrap", {31'b0, oWrap}, 0);

    // PC wrap and SP borrow
    req(OP_LDPC, 16'hFFFF);
    chk("ldpc_pc", {16'b0, oPC}, 32'hFFFF);
    req(OP_PCINC, 16'h0);
    chk("pcinc_pc", {16'b0, oPC}, 0);
    chk("pcinc_wrap", {31'b0, oWrap}, 1);
    chk("pcinc_done", {31'b0, oDone}, 1);
    req(OP_LDSP, 16'h0001);
    chk("ld_keeps_wrap", {31'b0, oWrap}, 1);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hFFFF);
    req(OP_PUSH2, 16'h0);
    chk("pushw_s1_wrap", {31'b0, oWrap}, 0);
    tick();
    tick();
    chk("pushw_sp", {16'b0, oSP}, 32'hFFFF);
    chk("pushw_wrap", {31'b0, oWrap}, 1);

    // PC_INC2 with requests held while busy
    req(OP_LDPC, 16'hFFFE);
    iReq  = 1'b1;
    iOp   = OP_PCINC2;
    tick();
    iOp   = OP_LDPC;
    iData = 16'h1234;
    chk("pinc2_busy", {31'b0, oBusy}, 1);
    chk("pinc2_mid_pc", {16'b0, oPC}, 32'hFFFF);
    tick();
    chk("pinc2_s2_pc", {16'b0, oPC}, 0);
    tick();
    iReq = 1'b0;
    chk("pinc2_done", {31'b0, oDone}, 1);
    chk("pinc2_pc", {16'b0, oPC}, 0);
    chk("pinc2_wrap", {31'b0, oWrap}, 1);
    tick();
    chk("busy_req_ignored", {16'b0, oPC}, 0);

    // back-to-back PC_INC
    req(OP_LDPC, 16'h0100);
    done_cnt = 0;
    iReq = 1'b1;
    iOp  = OP_PCINC;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b2b_busy", {31'b0, oBusy}, 0);
      chk("b2b_done", {31'b0, oDone}, 1);
    end
    iReq = 1'b0;
    chk("b2b_pc", {16'b0, oPC}, 32'h0105);
    chk("b2b_ndone", done_cnt, 5);
    chk("b2b_wrap", {31'b0, oWrap}, 0);

    // reset in the middle of PUSH2
    req(OP_LDSP, 16'h1000);
    exp_q.push_back(16'h0FFF);
    exp_q.push_back(16'h0FFE);
    req(OP_PUSH2, 16'h0);
    chk("mid_sp", {16'b0, oSP}, 32'h0FFF);
    #1;
    iRstN = 1'b0;
    #1;
    chk("arst_pc", {16'b0, oPC}, 0);
    chk("arst_sp", {16'b0, oSP}, 0);
    chk("arst_busy", {31'b0, oBusy}, 0);
    chk("arst_step", {31'b0, oStep}, 0);
    exp_q.delete();
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_busy", {31'b0, oBusy}, 0);
      chk("post_rst_step", {31'b0, oStep}, 0);
    end
    chk("post_rst_sp", {16'b0, oSP}, 0);
    chk("q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
